// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
//   rx_data    : received word, LSB = first bit on the line
//   rx_valid   : rx_data and its status are valid; held until accepted
//   rx_ready   : consumer accepts rx_data this cycle
//   parity_err : parity mismatch on the held frame
//   frame_err  : a stop bit was sampled low on the held frame
// master = receiver (drives the frame), slave = consumer (drives rx_ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with synchroniser, false-start rejection,
// optional parity, 1/2 stop bits and a one-entry valid/ready holding register.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   rx_i        : asynchronous serial line (idles high)
//   rx_if       : master side of uart_rx_param_if (data/valid/ready/status)
//   overrun_o   : sticky, a completed frame was dropped (holding reg full)
//   busy_o      : FSM is not in IDLE
module uart_rx_param #(
  parameter int BIT_CLKS    = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  uart_rx_param_if.master rx_if,
  output logic            overrun_o,
  output logic            busy_o
);
  localparam int CW = $clog2(BIT_CLKS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_C  = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] LAST_C  = CW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] DLAST_C = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST_C = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Synchroniser and edge flop reset high so reset release on an idle
  // line never looks like a start edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d_q;
  logic                   rx_s;
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_d_q <= rx_s;
    end
  end

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done;
  logic                 tick;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 accept, load;

  assign tick = (cnt_q == LAST_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame FSM. The clock counter runs 0..BIT_CLKS-1 between samples; the
  // START phase instead counts up to BIT_CLKS/2 to land on the bit centre.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_d_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = IDLE;  // false start: glitch shorter than half a bit
          end
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};  // LSB arrives first
          bit_d   = bit_q + BW'(1);
          if (bit_q == DLAST_C) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s) != PAR_ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (bit_q == SLAST_C) begin
            // Back to IDLE at the centre of the last stop bit so a following
            // start edge is caught immediately.
            state_d = IDLE;
            bit_d   = '0;
            done    = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register. A frame completing in the same cycle as an accept
  // replaces the held word without counting as an overrun.
  assign accept = valid_q & rx_if.rx_ready;
  assign load   = done & (~valid_q | rx_if.rx_ready);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      pe_d    = perr_q;
      fe_d    = ferr_d;  // includes the stop sample taken this cycle
    end else if (done) begin
      ovr_d = 1'b1;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.frame_err  = fe_q;
  assign overrun_o        = ovr_q;
  assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  localparam int B = 16;
  localparam int H = B / 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxl = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [2:0] ovr, bsy;
  logic [2:0] mv, mpe, mfe;
  logic [2:0][8:0] md;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  // inst 0: 8N1, inst 1: 7E1, inst 2: 8N2
  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(7)) ifb ();
  uart_rx_param_if #(.DATA_BITS(8)) ifc ();

  uart_rx_param #(.BIT_CLKS(B), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst(rst), .rx_i(rxl[0]), .rx_if(ifa.master),
    .overrun_o(ovr[0]), .busy_o(bsy[0]));
  uart_rx_param #(.BIT_CLKS(B), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst), .rx_i(rxl[1]), .rx_if(ifb.master),
    .overrun_o(ovr[1]), .busy_o(bsy[1]));
  uart_rx_param #(.BIT_CLKS(B), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .SYNC_STAGES(S)) dut_c (
    .clk(clk), .rst(rst), .rx_i(rxl[2]), .rx_if(ifc.master),
    .overrun_o(ovr[2]), .busy_o(bsy[2]));

  assign ifa.rx_ready = rdy[0];
  assign ifb.rx_ready = rdy[1];
  assign ifc.rx_ready = rdy[2];
  assign mv  = {ifc.rx_valid, ifb.rx_valid, ifa.rx_valid};
  assign mpe = {ifc.parity_err, ifb.parity_err, ifa.parity_err};
  assign mfe = {ifc.frame_err, ifb.frame_err, ifa.frame_err};
  assign md[0] = {1'b0, ifa.rx_data};
  assign md[1] = {2'b0, ifb.rx_data};
  assign md[2] = {1'b0, ifc.rx_data};

  // Expected deliveries {parity_err, frame_err, data}, one queue per instance.
  logic [10:0] q0[$], q1[$], q2[$];

  typedef struct {
    int          inst;
    logic [8:0]  d;
    logic        p;
    logic [1:0]  st;   // st[0] = first stop bit on the line
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [10:0] e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int i);
    logic [10:0] e;
    logic        ok;
    ok = 1'b1;
    e  = '0;
    case (i)
      0: if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
    endcase
    if (!ok) begin
      n_checks++;
      n_errs++;
      $display("FAIL sb_unexpected%0d: got %0h expected no frame", i, {mpe[i], mfe[i], md[i]});
    end else begin
      chk($sformatf("sb_frame%0d", i), {21'b0, mpe[i], mfe[i], md[i]}, {21'b0, e});
    end
  endtask

  // A new word is visible when valid rises, or stays high across an edge
  // at which the consumer accepted (replacement load).
  logic [2:0] pv = 3'b000;
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (mv[i] && (!pv[i] || rdy[i])) sb_pop(i);
    pv <= mv;
  end

  task automatic drive_bit(input int i, input logic b);
    @(negedge clk);
    rxl[i] = b;
    repeat (B - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input logic p, input logic [1:0] st);
    int nd, ns;
    nd = (i == 1) ? 7 : 8;
    ns = (i == 2) ? 2 : 1;
    drive_bit(i, 1'b0);
    for (int k = 0; k < nd; k++) drive_bit(i, d[k]);
    if (i == 1) drive_bit(i, p);
    for (int k = 0; k < ns; k++) drive_bit(i, st[k]);
  endtask

  task automatic pulse_ready(input int i);
    chk($sformatf("held%0d", i), mv[i], 1);
    @(negedge clk);
    rdy[i] = 1'b1;
    @(negedge clk);
    rdy[i] = 1'b0;
    chk($sformatf("valid_fall%0d", i), mv[i], 0);
  endtask

  initial begin
    logic saw;
    tbl[0] = '{0, 9'h000, 1'b0, 2'b11, {2'b00, 9'h000}};
    tbl[1] = '{0, 9'h0FF, 1'b0, 2'b11, {2'b00, 9'h0FF}};
    tbl[2] = '{0, 9'h05A, 1'b0, 2'b11, {2'b00, 9'h05A}};
    tbl[3] = '{0, 9'h081, 1'b0, 2'b00, {2'b01, 9'h081}};
    tbl[4] = '{1, 9'h041, 1'b0, 2'b11, {2'b00, 9'h041}};
    tbl[5] = '{1, 9'h041, 1'b1, 2'b11, {2'b10, 9'h041}};
    tbl[6] = '{1, 9'h007, 1'b1, 2'b11, {2'b00, 9'h007}};
    tbl[7] = '{1, 9'h07F, 1'b0, 2'b11, {2'b10, 9'h07F}};
    tbl[8] = '{2, 9'h096, 1'b0, 2'b11, {2'b00, 9'h096}};
    tbl[9] = '{2, 9'h096, 1'b0, 2'b10, {2'b01, 9'h096}};

    repeat (4) @(negedge clk);
    chk("rst_valid", mv, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_data", md[0], 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5 latency: valid rises on the edge after the stop-bit centre.
    push(0, {2'b00, 9'h0A5});
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11);
      begin
        repeat (S + 2 + H + 9 * B) @(negedge clk);
        chk("a5_before_rise", mv[0], 0);
        @(negedge clk);
        chk("a5_rise", mv[0], 1);
      end
    join
    repeat (5) @(negedge clk);
    pulse_ready(0);

    for (int t = 0; t < 10; t++) begin
      push(tbl[t].inst, tbl[t].exp);
      send_frame(tbl[t].inst, tbl[t].d, tbl[t].p, tbl[t].st);
      @(negedge clk);
      rxl[tbl[t].inst] = 1'b1;
      repeat (B) @(negedge clk);
      pulse_ready(tbl[t].inst);
    end

    // Second stop bit low, line held in break, then released.
    push(2, {2'b01, 9'h03C});
    send_frame(2, 9'h03C, 1'b0, 2'b01);
    repeat (3 * B) @(negedge clk);
    rxl[2] = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("break_busy", bsy[2], 0);
    chk("break_ovr", ovr[2], 0);
    pulse_ready(2);

    // Short low glitch: false start, no frame.
    saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) rxl[0] = 1'b0;
      if (c == B / 4) rxl[0] = 1'b1;
      saw = saw | bsy[0];
    end
    chk("glitch_busy_seen", saw, 1);
    chk("glitch_busy_end", bsy[0], 0);
    chk("glitch_no_valid", mv[0], 0);

    // Back-to-back with no consumer: second frame dropped.
    push(0, {2'b00, 9'h011});
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    chk("drop_data", md[0], 9'h011);
    chk("drop_ovr", ovr[0], 1);
    pulse_ready(0);
    chk("ovr_clear", ovr[0], 0);

    // Same, with ready exactly at the second frame's completion cycle.
    push(0, {2'b00, 9'h011});
    push(0, {2'b00, 9'h022});
    fork
      begin
        send_frame(0, 9'h011, 1'b0, 2'b11);
        send_frame(0, 9'h022, 1'b0, 2'b11);
      end
      begin
        repeat (1 + 10 * B + S + 1 + H + 9 * B) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("b2b_data", md[0], 9'h022);
    chk("b2b_ovr", ovr[0], 0);
    pulse_ready(0);

    // Reset in the middle of DATA with a frame already held.
    push(0, {2'b00, 9'h05A});
    send_frame(0, 9'h05A, 1'b0, 2'b11);
    @(negedge clk);
    rxl[0] = 1'b0;
    repeat (3 * B) @(negedge clk);
    chk("pre_rst_busy", bsy[0], 1);
    chk("pre_rst_valid", mv[0], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", mv[0], 0);
    chk("midrst_data", md[0], 0);
    chk("midrst_busy", bsy[0], 0);
    chk("midrst_flags", {ovr[0], mpe[0], mfe[0]}, 0);
    rxl[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    push(0, {2'b00, 9'h03C});
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    repeat (2) @(negedge clk);
    pulse_ready(0);

    repeat (4) @(negedge clk);
    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    chk("sb_left2", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
